dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the byte-lane data memory (four 8-bit block-RAM banks, 1-cycle synchronous read).
- Shares the memory between the CPU load/store port (port 0) and a secondary master such as a DMA or debug engine (port 1).
- Latches one request at a time, checks alignment, drives the memory for exactly one access cycle, captures read data and returns a done pulse with status.
- Sits between the MEM pipeline stage / DMA and the data memory instance.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/dmem_arb_pick.sv | 46 ++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory path.
// Contents:
//   W_BYTE / W_HALF / W_WORD : access width encodings (2'b10 is illegal)
//   state_t                  : arbiter FSM states
//   misaligned()             : alignment / illegal-width check, also used by
//                              the memory wrapper and the exception unit
package dmem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // True when the access must not touch memory: illegal width encoding,
  // odd halfword, or word not on a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] width,
                                      input logic [1:0] adr_lo);
    return (width == 2'b10) ||
           (width == W_HALF && adr_lo[0]) ||
           (width == W_WORD && adr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Requester side (per port n = 0/1):
//   pn_req_i, pn_we_i, pn_width_i, pn_sign_i, pn_adr_i, pn_dat_i : request
//   pn_gnt_o  : request accepted this cycle (combinational)
//   pn_done_o : one-cycle completion pulse; rdata_o / err_o valid with it
// Memory side:
//   mem_wen_o, mem_width_o, mem_sign_o, mem_adr_o, mem_dat_o : access
//   mem_dat_i : lane-selected, extended read data, one cycle after access
// Handshake: a requester raises req with its fields and holds them stable
// until the cycle in which gnt is high; the request is taken on that clock
// edge. Dropping req before gnt withdraws it with no side effect. Exactly
// one done pulse follows each gnt unless reset intervenes.
// Modports: slave = arbiter view, master = requester/memory (bench) view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              p0_req_i;
  logic              p0_we_i;
  logic [1:0]        p0_width_i;
  logic              p0_sign_i;
  logic [ADDR_W-1:0] p0_adr_i;
  logic [31:0]       p0_dat_i;
  logic              p0_gnt_o;
  logic              p0_done_o;

  logic              p1_req_i;
  logic              p1_we_i;
  logic [1:0]        p1_width_i;
  logic              p1_sign_i;
  logic [ADDR_W-1:0] p1_adr_i;
  logic [31:0]       p1_dat_i;
  logic              p1_gnt_o;
  logic              p1_done_o;

  logic [31:0]       rdata_o;
  logic              err_o;

  logic              mem_wen_o;
  logic [1:0]        mem_width_o;
  logic              mem_sign_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic [31:0]       mem_dat_o;
  logic [31:0]       mem_dat_i;

  modport slave (
    input  p0_req_i, p0_we_i, p0_width_i, p0_sign_i, p0_adr_i, p0_dat_i,
    input  p1_req_i, p1_we_i, p1_width_i, p1_sign_i, p1_adr_i, p1_dat_i,
    output p0_gnt_o, p0_done_o, p1_gnt_o, p1_done_o, rdata_o, err_o,
    output mem_wen_o, mem_width_o, mem_sign_o, mem_adr_o, mem_dat_o,
    input  mem_dat_i
  );

  modport master (
    output p0_req_i, p0_we_i, p0_width_i, p0_sign_i, p0_adr_i, p0_dat_i,
    output p1_req_i, p1_we_i, p1_width_i, p1_sign_i, p1_adr_i, p1_dat_i,
    input  p0_gnt_o, p0_done_o, p1_gnt_o, p1_done_o, rdata_o, err_o,
    input  mem_wen_o, mem_width_o, mem_sign_o, mem_adr_o, mem_dat_o,
    output mem_dat_i
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Winner selection and port-1 starvation counter.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   idle_i                : arbiter can accept a request this cycle
//   p0_req_i, p1_req_i    : raw requests
//   p0_gnt_o, p1_gnt_o    : combinational grants, at most one high
//   wait_cnt_o            : cycles port 1 has waited (saturates at WAIT_MAX)
module dmem_arb_pick #(
  parameter int WAIT_MAX = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              idle_i,
  input  logic              p0_req_i,
  input  logic              p1_req_i,
  output logic              p0_gnt_o,
  output logic              p1_gnt_o,
  output logic [WAIT_W-1:0] wait_cnt_o
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic              p1_wins;

  // Port 0 has priority until port 1 has waited WAIT_MAX cycles.
  assign p1_wins  = p1_req_i && (!p0_req_i || wait_cnt_q == WAIT_LIM);
  assign p1_gnt_o = idle_i && p1_wins;
  assign p0_gnt_o = idle_i && p0_req_i && !p1_wins;

  assign wait_cnt_o = wait_cnt_q;

  // Counts every cycle port 1 asks and is refused, including cycles where
  // the arbiter is busy with another access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (!p1_req_i || p1_gnt_o) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != WAIT_LIM) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the byte-lane data memory.
// One request is latched at a time, driven to memory for one cycle, and
// answered with a done pulse plus rdata/err.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : requester + memory bundle (slave modport)
//   state_o      : current FSM state (debug)
//   wait_cnt_o   : port-1 starvation counter (debug)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_arbiter_if.slave     bus,
  output state_t            state_o,
  output logic [WAIT_W-1:0] wait_cnt_o
);

  state_t            state_q, state_d;
  logic              p0_gnt, p1_gnt;
  logic              we_q, sign_q, owner_q;
  logic [1:0]        width_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic [31:0]       rdata_q;
  logic              err_q, done0_q, done1_q;
  logic              mis;

  dmem_arb_pick #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_pick (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idle_i     (state_q == ST_IDLE),
    .p0_req_i   (bus.p0_req_i),
    .p1_req_i   (bus.p1_req_i),
    .p0_gnt_o   (p0_gnt),
    .p1_gnt_o   (p1_gnt),
    .wait_cnt_o (wait_cnt_o)
  );

  assign mis = misaligned(width_q, adr_q[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (p0_gnt || p1_gnt) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      width_q <= 2'b00;
      sign_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // The latches feed the memory outputs directly, so they only change
      // on a grant and otherwise hold the last access on the memory bus.
      if (p1_gnt) begin
        we_q    <= bus.p1_we_i;
        width_q <= bus.p1_width_i;
        sign_q  <= bus.p1_sign_i;
        adr_q   <= bus.p1_adr_i;
        dat_q   <= bus.p1_dat_i;
        owner_q <= 1'b1;
      end else if (p0_gnt) begin
        we_q    <= bus.p0_we_i;
        width_q <= bus.p0_width_i;
        sign_q  <= bus.p0_sign_i;
        adr_q   <= bus.p0_adr_i;
        dat_q   <= bus.p0_dat_i;
        owner_q <= 1'b0;
      end
      done0_q <= (state_q == ST_RESP) && !owner_q;
      done1_q <= (state_q == ST_RESP) && owner_q;
      if (state_q == ST_RESP) begin
        // Stores and rejected accesses return zero rather than stale data.
        rdata_q <= (we_q || mis) ? 32'h0 : bus.mem_dat_i;
        err_q   <= mis;
      end
    end
  end

  assign bus.p0_gnt_o    = p0_gnt;
  assign bus.p1_gnt_o    = p1_gnt;
  assign bus.p0_done_o   = done0_q;
  assign bus.p1_done_o   = done1_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.mem_wen_o   = (state_q == ST_ISSUE) && we_q && !mis;
  assign bus.mem_width_o = width_q;
  assign bus.mem_sign_o  = sign_q;
  assign bus.mem_adr_o   = adr_q;
  assign bus.mem_dat_o   = dat_q;

  assign state_o = state_q;

endmodule
